// File: rtl/mc_mips_pkg.sv
// Shared constants for the multi-cycle MIPS core: opcodes, functs, FSM encoding, ALU ops.
// The optional bne decode is selected in mc_mips_core by MC_MIPS_BNE_EN.
package mc_mips_pkg;
    localparam int XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_LOAD   = 3'd5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;
endpackage

// File: rtl/mc_mips_alu.sv
// Shared combinational ALU of the multi-cycle core; zero flags an all-zero result.
module mc_mips_alu
    import mc_mips_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/mc_mips_core.sv
// Multi-cycle MIPS-I subset core with host instruction-load port and debug register view.
// Define MC_MIPS_BNE_EN to decode bne (opcode 6'h05); otherwise it is treated as illegal.
module mc_mips_core
    import mc_mips_pkg::*;
#(
    parameter int          IMEM_AW  = 6,
    parameter int          DMEM_AW  = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WE,
    input  logic [31:0] W_Ins,
    input  logic [4:0]  SLCT,
    output logic [31:0] PC,
    output logic [31:0] Result,
    output logic [2:0]  STATE,
    output logic        RETIRE,
    output logic        ILL
);
    logic [2:0]         state_reg, state_next;
    logic [XLEN-1:0]    pc_reg, ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
    logic [IMEM_AW-1:0] ldptr_reg;
    logic               ill_reg;
    logic [XLEN-1:0]    regs [32];
    logic [31:0]        imem [2**IMEM_AW];
    logic [31:0]        dmem [2**DMEM_AW];

    logic [5:0]      opcode, funct;
    logic [4:0]      rs, rt, rd, wb_addr;
    logic [XLEN-1:0] imm_ext, alu_b, alu_result, wb_data;
    logic            alu_zero, is_r_ok, is_j, is_beq, is_bne, is_addi, is_lw, is_sw;
    logic            is_branch, is_legal, branch_taken;
    alu_op_t         alu_op;

    assign opcode  = ir_reg[31:26];
    assign rs      = ir_reg[25:21];
    assign rt      = ir_reg[20:16];
    assign rd      = ir_reg[15:11];
    assign funct   = ir_reg[5:0];
    assign imm_ext = {{16{ir_reg[15]}}, ir_reg[15:0]};

    assign is_r_ok = (opcode == OP_RTYPE) &&
                     (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                      funct == FN_OR  || funct == FN_SLT);
    assign is_j    = (opcode == OP_J);
    assign is_beq  = (opcode == OP_BEQ);
`ifdef MC_MIPS_BNE_EN
    assign is_bne  = (opcode == OP_BNE);
`else
    assign is_bne  = 1'b0;
`endif
    assign is_addi   = (opcode == OP_ADDI);
    assign is_lw     = (opcode == OP_LW);
    assign is_sw     = (opcode == OP_SW);
    assign is_branch = is_beq || is_bne;
    assign is_legal  = is_r_ok || is_j || is_branch || is_addi || is_lw || is_sw;

    always_comb begin
        alu_op = ALU_ADD;
        if (is_branch) begin
            alu_op = ALU_SUB;
        end else if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

    assign alu_b = (opcode == OP_RTYPE || is_branch) ? b_reg : imm_ext;

    mc_mips_alu u_alu (
        .a      (a_reg),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign branch_taken = is_beq ? alu_zero : (is_bne && !alu_zero);
    assign wb_addr      = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_data      = is_lw ? mdr_reg : alu_out_reg;

    always_comb begin
        state_next = state_reg;
        if (WE) begin
            state_next = ST_LOAD;
        end else begin
            case (state_reg)
                ST_FETCH:  state_next = ST_DECODE;
                ST_DECODE: state_next = (is_j || !is_legal) ? ST_FETCH : ST_EXEC;
                ST_EXEC:   state_next = is_branch ? ST_FETCH :
                                        ((is_lw || is_sw) ? ST_MEM : ST_WB);
                ST_MEM:    state_next = is_sw ? ST_FETCH : ST_WB;
                default:   state_next = ST_FETCH;
            endcase
        end
    end

    // A WE request aborts whatever is in flight, so retirement is masked by it.
    always_comb begin
        RETIRE = 1'b0;
        if (RST && !WE) begin
            case (state_reg)
                ST_DECODE: RETIRE = is_j || !is_legal;
                ST_EXEC:   RETIRE = is_branch;
                ST_MEM:    RETIRE = is_sw;
                ST_WB:     RETIRE = 1'b1;
                default:   RETIRE = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg   <= ST_FETCH;
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out_reg <= '0;
            mdr_reg     <= '0;
            ldptr_reg   <= '0;
            ill_reg     <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            state_reg <= state_next;
            if (WE) begin
                if (state_reg == ST_LOAD) ldptr_reg <= ldptr_reg + 1'b1;
            end else begin
                case (state_reg)
                    ST_FETCH: begin
                        ir_reg <= imem[pc_reg[IMEM_AW+1:2]];
                        pc_reg <= pc_reg + 32'd4;
                    end
                    ST_DECODE: begin
                        a_reg <= regs[rs];
                        b_reg <= regs[rt];
                        if (is_j) pc_reg <= {pc_reg[31:28], ir_reg[25:0], 2'b00};
                        if (!is_legal) ill_reg <= 1'b1;
                    end
                    ST_EXEC: begin
                        alu_out_reg <= alu_result;
                        if (branch_taken) pc_reg <= pc_reg + {imm_ext[29:0], 2'b00};
                    end
                    ST_MEM: begin
                        if (is_lw) mdr_reg <= dmem[alu_out_reg[DMEM_AW+1:2]];
                    end
                    ST_WB: begin
                        if (wb_addr != 5'd0) regs[wb_addr] <= wb_data;
                    end
                    ST_LOAD: begin
                        ldptr_reg <= '0;
                        pc_reg    <= RESET_PC;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memories carry no reset so their contents survive both reset and load sessions.
    always_ff @(posedge CLK) begin
        if (RST && WE && state_reg == ST_LOAD) imem[ldptr_reg] <= W_Ins;
        if (RST && !WE && state_reg == ST_MEM && is_sw) dmem[alu_out_reg[DMEM_AW+1:2]] <= b_reg;
    end

    assign PC     = pc_reg;
    assign STATE  = state_reg;
    assign ILL    = ill_reg;
    assign Result = (SLCT == 5'd0) ? '0 : regs[SLCT];
endmodule

// File: tb/tb_mc_mips_core.sv
// Directed self-checking bench for mc_mips_core: load, execute, branch, abort, illegal and reset.
module tb_mc_mips_core;
    import mc_mips_pkg::*;

    logic        clk, rst, we;
    logic [31:0] w_ins;
    logic [4:0]  slct;
    logic [31:0] pc, result;
    logic [2:0]  state;
    logic        retire, ill;

    int total = 0;
    int bad   = 0;
    int ret_cnt, ret_first, ret_last;
    logic [31:0] prog [$];
    logic [31:0] v;

    mc_mips_core dut (
        .CLK    (clk),
        .RST    (rst),
        .WE     (we),
        .W_Ins  (w_ins),
        .SLCT   (slct),
        .PC     (pc),
        .Result (result),
        .STATE  (state),
        .RETIRE (retire),
        .ILL    (ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs_f,
                                          input logic [4:0] rt_f, input logic [15:0] imm);
        return {op, rs_f, rt_f, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                          input logic [4:0] rd_f, input logic [5:0] fn);
        return {6'h00, rs_f, rt_f, rd_f, 5'd0, fn};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] r, output logic [31:0] val);
        slct = r;
        #1;
        val = result;
    endtask

    task automatic load_prog;
        we = 1'b1;
        tick();
        for (int i = 0; i < prog.size(); i++) begin
            w_ins = prog[i];
            tick();
        end
        we = 1'b0;
        tick();
    endtask

    task automatic run(input int n);
        ret_cnt = 0; ret_first = 0; ret_last = 0;
        for (int i = 1; i <= n; i++) begin
            if (retire === 1'b1) begin
                ret_cnt++;
                if (ret_first == 0) ret_first = i;
                ret_last = i;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; we = 1'b0; w_ins = '0; slct = '0;
        tick(); tick();
        rst = 1'b1;
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h0); end
        total++; if (state !== ST_FETCH) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state, ST_FETCH); end
        total++; if (retire !== 1'b0) begin bad++; $display("FAIL reset_retire got=%b want=0", retire); end
        total++; if (ill !== 1'b0) begin bad++; $display("FAIL reset_ill got=%b want=0", ill); end
        rd(5'd31, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_r31 got=%h want=0", v); end
        $display("reset: pc=%h state=%0d", pc, state);
    endtask

    task automatic test_arith;
        prog = '{enc_i(OP_ADDI, 0, 1, 16'd5), enc_i(OP_ADDI, 0, 2, 16'd7), enc_r(1, 2, 3, FN_ADD)};
        load_prog();
        total++; if (pc !== 32'h0 || state !== ST_FETCH) begin bad++; $display("FAIL load_exit got=pc %h st %0d want=pc 0 st 0", pc, state); end
        run(12);
        rd(5'd3, v);
        total++; if (v !== 32'd12) begin bad++; $display("FAIL arith_r3 got=%h want=%h", v, 32'd12); end
        total++; if (ret_cnt !== 3) begin bad++; $display("FAIL arith_retires got=%0d want=3", ret_cnt); end
        total++; if (ret_first !== 4) begin bad++; $display("FAIL arith_first_retire got=%0d want=4", ret_first); end
        total++; if (pc !== 32'd12) begin bad++; $display("FAIL arith_pc got=%h want=%h", pc, 32'd12); end
        $display("arith: r3=%0d retires=%0d", v, ret_cnt);
    endtask

    task automatic test_mem;
        prog = '{enc_i(OP_SW, 0, 3, 16'd4), enc_i(OP_LW, 0, 4, 16'd4)};
        load_prog();
        run(9);
        rd(5'd4, v);
        total++; if (v !== 32'd12) begin bad++; $display("FAIL mem_r4 got=%h want=%h", v, 32'd12); end
        total++; if (ret_cnt !== 2) begin bad++; $display("FAIL mem_retires got=%0d want=2", ret_cnt); end
        total++; if (ret_first !== 4) begin bad++; $display("FAIL mem_sw_retire got=%0d want=4", ret_first); end
        total++; if (ret_last !== 9) begin bad++; $display("FAIL mem_lw_retire got=%0d want=9", ret_last); end
        $display("mem: r4=%0d retire cycles %0d,%0d", v, ret_first, ret_last);
    endtask

    task automatic test_alu_ops;
        prog = '{enc_r(1, 2, 6, FN_SUB), enc_r(6, 1, 7, FN_SLT), enc_r(1, 6, 11, FN_SLT),
                 enc_r(1, 2, 8, FN_AND), enc_r(1, 2, 9, FN_OR), enc_i(OP_ADDI, 0, 10, 16'hFFFF),
                 enc_i(OP_ADDI, 0, 0, 16'd9), enc_r(0, 1, 12, FN_ADD)};
        load_prog();
        run(32);
        total++; if (ret_cnt !== 8) begin bad++; $display("FAIL alu_retires got=%0d want=8", ret_cnt); end
        rd(5'd6, v);
        total++; if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL alu_sub got=%h want=fffffffe", v); end
        rd(5'd7, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL alu_slt_neg got=%h want=1", v); end
        rd(5'd11, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL alu_slt_signed got=%h want=0", v); end
        rd(5'd8, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL alu_and got=%h want=5", v); end
        rd(5'd9, v);
        total++; if (v !== 32'd7) begin bad++; $display("FAIL alu_or got=%h want=7", v); end
        rd(5'd10, v);
        total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL alu_addi_neg got=%h want=ffffffff", v); end
        rd(5'd12, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL alu_r0_discard got=%h want=5", v); end
        $display("alu_ops: retires=%0d", ret_cnt);
    endtask

    task automatic test_branch;
        prog = '{enc_i(OP_BEQ, 1, 1, 16'd1), enc_i(OP_ADDI, 0, 5, 16'd1), 32'h0800_0000};
        load_prog();
        run(3);
        total++; if (pc !== 32'd8) begin bad++; $display("FAIL beq_pc got=%h want=8", pc); end
        total++; if (ret_last !== 3 || ret_cnt !== 1) begin bad++; $display("FAIL beq_retire got=%0d/%0d want=3/1", ret_last, ret_cnt); end
        run(2);
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL j_pc got=%h want=0", pc); end
        total++; if (ret_last !== 2) begin bad++; $display("FAIL j_retire got=%0d want=2", ret_last); end
        rd(5'd5, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL beq_skip_r5 got=%h want=0", v); end
        $display("branch: pc=%h r5=%0d", pc, v);
    endtask

    task automatic test_abort;
        prog = '{enc_r(1, 2, 13, FN_ADD)};
        load_prog();
        run(3);
        total++; if (state !== ST_WB) begin bad++; $display("FAIL abort_in_wb got=%0d want=%0d", state, ST_WB); end
        we = 1'b1;
        #1;
        total++; if (retire !== 1'b0) begin bad++; $display("FAIL abort_retire got=%b want=0", retire); end
        tick();
        total++; if (state !== ST_LOAD) begin bad++; $display("FAIL abort_to_load got=%0d want=%0d", state, ST_LOAD); end
        we = 1'b0;
        tick();
        total++; if (pc !== 32'h0 || state !== ST_FETCH) begin bad++; $display("FAIL abort_exit got=pc %h st %0d want=pc 0 st 0", pc, state); end
        rd(5'd13, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL abort_r13 got=%h want=0", v); end
        run(4);
        rd(5'd13, v);
        total++; if (v !== 32'd12) begin bad++; $display("FAIL abort_rerun_r13 got=%h want=%h", v, 32'd12); end
        $display("abort: r13 after rerun=%0d", v);
    endtask

    task automatic test_bne;
        int exp_cyc;
        logic [31:0] exp_pc;
        logic exp_ill;
`ifdef MC_MIPS_BNE_EN
        exp_cyc = 3; exp_pc = 32'd8; exp_ill = 1'b0;
`else
        exp_cyc = 2; exp_pc = 32'd4; exp_ill = 1'b1;
`endif
        prog = '{enc_i(OP_BNE, 1, 2, 16'd1)};
        load_prog();
        total++; if (ill !== 1'b0) begin bad++; $display("FAIL bne_pre_ill got=%b want=0", ill); end
        run(exp_cyc);
        total++; if (pc !== exp_pc) begin bad++; $display("FAIL bne_pc got=%h want=%h", pc, exp_pc); end
        total++; if (ret_last !== exp_cyc) begin bad++; $display("FAIL bne_retire got=%0d want=%0d", ret_last, exp_cyc); end
        total++; if (ill !== exp_ill) begin bad++; $display("FAIL bne_ill got=%b want=%b", ill, exp_ill); end
        $display("bne: pc=%h ill=%b", pc, ill);
    endtask

    task automatic test_illegal;
        prog = '{32'hFC00_0000};
        load_prog();
        run(2);
        total++; if (ill !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b want=1", ill); end
        total++; if (ret_last !== 2 || ret_cnt !== 1) begin bad++; $display("FAIL ill_retire got=%0d/%0d want=2/1", ret_last, ret_cnt); end
        total++; if (pc !== 32'd4) begin bad++; $display("FAIL ill_pc got=%h want=4", pc); end
        rd(5'd1, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL ill_r1 got=%h want=5", v); end
        $display("illegal: ill=%b pc=%h", ill, pc);
    endtask

    task automatic test_reset_mid;
        prog = '{enc_i(OP_ADDI, 0, 1, 16'd5), enc_i(OP_ADDI, 0, 2, 16'd7), enc_r(1, 2, 3, FN_ADD)};
        load_prog();
        run(6);
        rst = 1'b0; we = 1'b1;
        tick();
        rst = 1'b1; we = 1'b0;
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL rstmid_pc got=%h want=0", pc); end
        total++; if (state !== ST_FETCH) begin bad++; $display("FAIL rstmid_state got=%0d want=0", state); end
        total++; if (ill !== 1'b0) begin bad++; $display("FAIL rstmid_ill got=%b want=0", ill); end
        rd(5'd1, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL rstmid_r1 got=%h want=0", v); end
        rd(5'd12, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL rstmid_r12 got=%h want=0", v); end
        run(12);
        rd(5'd3, v);
        total++; if (v !== 32'd12) begin bad++; $display("FAIL rstmid_imem_kept got=%h want=%h", v, 32'd12); end
        total++; if (ret_cnt !== 3) begin bad++; $display("FAIL rstmid_retires got=%0d want=3", ret_cnt); end
        $display("reset_mid: r3 after rerun=%0d", v);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_mem();
        test_alu_ops();
        test_branch();
        test_abort();
        test_bne();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
